// File: rtl/montgomery_exp_ctrl.sv
// -----------------------------------------------------------------------------
// montgomery_exp_ctrl
//
// Computes y = base^exponent mod m using left-to-right square-and-multiply.
// It drives one shared montgomery_mul (a*b*R^-1 mod m) through a pulse
// handshake. The same multiplier performs the conversion into the Montgomery
// domain (operand * R^2 mod m) and the conversion back out (operand * 1).
// m and m_size go straight from the top level to the multiplier, so this
// block never sees them.
//
// Optional feature: define MONT_EXP_PERF_CNT_EN to add the mul_cnt output.
// mul_cnt counts the multiplier start pulses of the current or most recent
// run and saturates at 0xFFFFFFFF.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_p      one-cycle start pulse, accepted only when idle
//   base         base in the conventional domain, < m
//   exponent     exponent, LSB-aligned
//   e_size       number of exponent bits used; values above EBITS use EBITS
//   r_red        R^2 mod m
//   mul_enable_p start pulse to the multiplier
//   mul_a/mul_b  multiplier operands (registered)
//   mul_y        multiplier result
//   mul_done_p   multiplier done pulse
//   y            result, held until the next run overwrites it
//   busy         high from the accepted start through the done cycle
//   done_irq_p   one-cycle completion pulse
//   mul_cnt      (MONT_EXP_PERF_CNT_EN only) multiplication counter
// -----------------------------------------------------------------------------
module montgomery_exp_ctrl #(
    parameter int NBITS = 2048,
    parameter int EBITS = 2048
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_p,
    input  logic [NBITS-1:0]         base,
    input  logic [EBITS-1:0]         exponent,
    input  logic [$clog2(EBITS):0]   e_size,
    input  logic [NBITS-1:0]         r_red,
    output logic                     mul_enable_p,
    output logic [NBITS-1:0]         mul_a,
    output logic [NBITS-1:0]         mul_b,
    input  logic [NBITS-1:0]         mul_y,
    input  logic                     mul_done_p,
    output logic [NBITS-1:0]         y,
    output logic                     busy,
    output logic                     done_irq_p
`ifdef MONT_EXP_PERF_CNT_EN
    ,
    output logic [31:0]              mul_cnt
`endif
);

    localparam int ESW = $clog2(EBITS) + 1;
    localparam int IW  = (EBITS > 1) ? $clog2(EBITS) : 1;
    localparam logic [ESW-1:0]   EMAX = ESW'(EBITS);
    localparam logic [NBITS-1:0] ONE  = {{(NBITS-1){1'b0}}, 1'b1};

    // Each multiplication is an ISSUE state (one cycle, enable pulse)
    // followed by a WAIT state that holds until the done pulse.
    typedef enum logic [3:0] {
        S_IDLE,
        S_CB_ISS, S_CB_WAIT,   // base -> Montgomery domain
        S_CO_ISS, S_CO_WAIT,   // 1 -> Montgomery domain (R mod m)
        S_SQ_ISS, S_SQ_WAIT,   // acc = acc^2
        S_MU_ISS, S_MU_WAIT,   // acc = acc * base_m
        S_FR_ISS, S_FR_WAIT,   // acc -> conventional domain
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NBITS-1:0]   acc_q, acc_d;
    logic [NBITS-1:0]   base_m_q, base_m_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [NBITS-1:0]   base_q, base_d;
    logic [EBITS-1:0]   exp_q, exp_d;
    logic [NBITS-1:0]   rred_q, rred_d;
    logic [ESW-1:0]     esize_q, esize_d;
    logic [NBITS-1:0]   y_q, y_d;
    logic [NBITS-1:0]   mul_a_q, mul_a_d;
    logic [NBITS-1:0]   mul_b_q, mul_b_d;
    logic               start_acc;

    assign start_acc = (state_q == S_IDLE) && start_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            base_m_q <= '0;
            idx_q    <= '0;
            base_q   <= '0;
            exp_q    <= '0;
            rred_q   <= '0;
            esize_q  <= '0;
            y_q      <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            base_m_q <= base_m_d;
            idx_q    <= idx_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            rred_q   <= rred_d;
            esize_q  <= esize_d;
            y_q      <= y_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        base_m_d = base_m_q;
        idx_d    = idx_q;
        base_d   = base_q;
        exp_d    = exp_q;
        rred_d   = rred_q;
        esize_d  = esize_q;
        y_d      = y_q;

        case (state_q)
            S_IDLE: begin
                if (start_p) begin
                    base_d  = base;
                    exp_d   = exponent;
                    rred_d  = r_red;
                    esize_d = (e_size > EMAX) ? EMAX : e_size;
                    state_d = S_CB_ISS;
                end
            end
            S_CB_ISS: state_d = S_CB_WAIT;
            S_CB_WAIT: begin
                if (mul_done_p) begin
                    base_m_d = mul_y;
                    state_d  = S_CO_ISS;
                end
            end
            S_CO_ISS: state_d = S_CO_WAIT;
            S_CO_WAIT: begin
                if (mul_done_p) begin
                    acc_d = mul_y;
                    if (esize_q == '0) begin
                        state_d = S_FR_ISS;
                    end else begin
                        idx_d   = IW'(esize_q - ESW'(1));
                        state_d = S_SQ_ISS;
                    end
                end
            end
            S_SQ_ISS: state_d = S_SQ_WAIT;
            S_SQ_WAIT: begin
                if (mul_done_p) begin
                    acc_d = mul_y;
                    if (exp_q[idx_q]) begin
                        state_d = S_MU_ISS;
                    end else if (idx_q == '0) begin
                        state_d = S_FR_ISS;
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        state_d = S_SQ_ISS;
                    end
                end
            end
            S_MU_ISS: state_d = S_MU_WAIT;
            S_MU_WAIT: begin
                if (mul_done_p) begin
                    acc_d = mul_y;
                    if (idx_q == '0) begin
                        state_d = S_FR_ISS;
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        state_d = S_SQ_ISS;
                    end
                end
            end
            S_FR_ISS: state_d = S_FR_WAIT;
            S_FR_WAIT: begin
                if (mul_done_p) begin
                    y_d     = mul_y;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Operands are loaded on the edge entering an ISSUE state, using the
        // values the state registers take on that same edge. They then stay
        // unchanged through the WAIT and on into IDLE.
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        case (state_d)
            S_CB_ISS: begin mul_a_d = base_d; mul_b_d = rred_d;   end
            S_CO_ISS: begin mul_a_d = ONE;    mul_b_d = rred_q;   end
            S_SQ_ISS: begin mul_a_d = acc_d;  mul_b_d = acc_d;    end
            S_MU_ISS: begin mul_a_d = acc_d;  mul_b_d = base_m_d; end
            S_FR_ISS: begin mul_a_d = acc_d;  mul_b_d = ONE;      end
            default:  ;
        endcase
    end

    assign mul_enable_p = (state_q == S_CB_ISS) || (state_q == S_CO_ISS) ||
                          (state_q == S_SQ_ISS) || (state_q == S_MU_ISS) ||
                          (state_q == S_FR_ISS);
    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign y            = y_q;
    assign busy         = (state_q != S_IDLE);
    assign done_irq_p   = (state_q == S_DONE);

`ifdef MONT_EXP_PERF_CNT_EN
    logic [31:0] mul_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_cnt_q <= '0;
        end else if (start_acc) begin
            mul_cnt_q <= '0;
        end else if (mul_enable_p && (mul_cnt_q != 32'hFFFF_FFFF)) begin
            mul_cnt_q <= mul_cnt_q + 32'd1;
        end
    end

    assign mul_cnt = mul_cnt_q;
`else
    // start_acc is only needed by the performance counter.
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for montgomery_exp_ctrl. NBITS=16, EBITS=8, m=187, m_size=8,
// r_red=86, with a behavioural 5-cycle Montgomery multiplier.
// -----------------------------------------------------------------------------
module tb_montgomery_exp_ctrl;

    localparam int NBITS = 16;
    localparam int EBITS = 8;
    localparam int M     = 187;
    localparam int RRED  = 86;
    localparam int LMUL  = 5;

    logic             clk;
    logic             rst_n;
    logic             start_p;
    logic [NBITS-1:0] base;
    logic [EBITS-1:0] exponent;
    logic [3:0]       e_size;
    logic [NBITS-1:0] r_red;
    logic             mul_enable_p;
    logic [NBITS-1:0] mul_a;
    logic [NBITS-1:0] mul_b;
    logic [NBITS-1:0] mul_y;
    logic             mul_done_p;
    logic [NBITS-1:0] y;
    logic             busy;
    logic             done_irq_p;
`ifdef MONT_EXP_PERF_CNT_EN
    logic [31:0]      mul_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    montgomery_exp_ctrl #(.NBITS(NBITS), .EBITS(EBITS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_p      (start_p),
        .base         (base),
        .exponent     (exponent),
        .e_size       (e_size),
        .r_red        (r_red),
        .mul_enable_p (mul_enable_p),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_y        (mul_y),
        .mul_done_p   (mul_done_p),
        .y            (y),
        .busy         (busy),
        .done_irq_p   (done_irq_p)
`ifdef MONT_EXP_PERF_CNT_EN
        ,
        .mul_cnt      (mul_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural multiplier ----------------
    function automatic int rinv_calc();
        for (int x = 1; x < M; x++)
            if (((256 * x) % M) == 1) return x;
        return 0;
    endfunction

    function automatic logic [NBITS-1:0] mont(input logic [NBITS-1:0] a,
                                               input logic [NBITS-1:0] b);
        longint t;
        t = ((longint'(a) * longint'(b)) % M) * longint'(rinv_calc());
        return NBITS'(t % M);
    endfunction

    int               mcnt;
    logic [NBITS-1:0] mres;
    logic [NBITS-1:0] cap_a;
    logic [NBITS-1:0] cap_b;
    logic             stray_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt  <= 0;
            mres  <= '0;
            cap_a <= '0;
            cap_b <= '0;
        end else if (mul_enable_p) begin
            mcnt  <= LMUL;
            mres  <= mont(mul_a, mul_b);
            cap_a <= mul_a;
            cap_b <= mul_b;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
        end
    end

    assign mul_done_p = (mcnt == 1) || stray_done;
    assign mul_y      = mres;

    // Event counters (single writer); tasks take differences.
    int en_total   = 0;
    int done_total = 0;
    always @(posedge clk) begin
        if (mul_enable_p) en_total   <= en_total + 1;
        if (done_irq_p)   done_total <= done_total + 1;
    end

    // ---------------- reference model ----------------
    function automatic int ref_esize(input int es);
        return (es > EBITS) ? EBITS : es;
    endfunction

    function automatic int ref_pow(input int b, input int e, input int es);
        int r;
        r = 1;
        for (int i = ref_esize(es) - 1; i >= 0; i--) begin
            r = (r * r) % M;
            if (((e >> i) & 1) == 1) r = (r * b) % M;
        end
        return r % M;
    endfunction

    function automatic int ref_muls(input int e, input int es);
        int n;
        n = 3 + ref_esize(es);
        for (int i = 0; i < ref_esize(es); i++)
            if (((e >> i) & 1) == 1) n++;
        return n;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One complete exponentiation with full checking.
    task automatic run_exp(input int b, input int e, input int es,
                           input bit repulse);
        int exp_y, exp_n, en0, dn0, cyc, busy_cyc;
        exp_y = ref_pow(b, e, es);
        exp_n = ref_muls(e, es);
        @(negedge clk);
        en0 = en_total;
        dn0 = done_total;
        base     = NBITS'(b);
        exponent = EBITS'(e);
        e_size   = 4'(es);
        r_red    = NBITS'(RRED);
        start_p  = 1'b1;
        @(negedge clk);
        start_p  = 1'b0;
        // Latched inputs are free to change after the start.
        base     = NBITS'($urandom_range(0, M - 1));
        exponent = EBITS'($urandom);
        e_size   = 4'($urandom);
        r_red    = NBITS'($urandom);
        cyc = 0;
        busy_cyc = 0;
        while (!done_irq_p && cyc < 400) begin
            if (busy) busy_cyc++;
            if (mcnt == 1) begin
                check_val("op_a_hold", 64'(mul_a), 64'(cap_a));
                check_val("op_b_hold", 64'(mul_b), 64'(cap_b));
            end
            cyc++;
            start_p = repulse && (cyc == 20);
            @(negedge clk);
        end
        start_p = 1'b0;
        check_val("done_seen", 64'(done_irq_p), 64'd1);
        check_val("busy_at_done", 64'(busy), 64'd1);
        busy_cyc++;
        check_val("latency", 64'(busy_cyc), 64'(exp_n * (1 + LMUL) + 1));
        @(negedge clk);
        check_val("busy_after", 64'(busy), 64'd0);
        check_val("y", 64'(y), 64'(exp_y));
        check_val("mul_count", 64'(en_total - en0), 64'(exp_n));
        check_val("done_count", 64'(done_total - dn0), 64'd1);
`ifdef MONT_EXP_PERF_CNT_EN
        check_val("mul_cnt", 64'(mul_cnt), 64'(exp_n));
`endif
        $display("run base=%0d exp=%0d e_size=%0d -> y=%0d muls=%0d (ref y=%0d muls=%0d)",
                 b, e, es, y, en_total - en0, exp_y, exp_n);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_y"},    64'(y), 64'd0);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_done"}, 64'(done_irq_p), 64'd0);
        check_val({tag, "_en"},   64'(mul_enable_p), 64'd0);
        check_val({tag, "_a"},    64'(mul_a), 64'd0);
        check_val({tag, "_b"},    64'(mul_b), 64'd0);
`ifdef MONT_EXP_PERF_CNT_EN
        check_val({tag, "_cnt"},  64'(mul_cnt), 64'd0);
`endif
    endtask

    initial begin
        int en0, dn0, cyc;
        logic [NBITS-1:0] y_hold;
        rst_n      = 1'b0;
        start_p    = 1'b0;
        stray_done = 1'b0;
        base       = '0;
        exponent   = '0;
        e_size     = '0;
        r_red      = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        run_exp(4, 13, 4, 1'b0);
        run_exp(4, 13, 0, 1'b0);
        run_exp(4, 0, 4, 1'b0);
        run_exp(0, 5, 3, 1'b0);
        run_exp(186, 2, 2, 1'b0);

        // Restart attempt while busy, then a stray done pulse while idle.
        run_exp(4, 13, 4, 1'b1);
        y_hold = y;
        dn0 = done_total;
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        check_val("stray_y", 64'(y), 64'(y_hold));
        check_val("stray_busy", 64'(busy), 64'd0);
        check_val("stray_done_cnt", 64'(done_total - dn0), 64'd0);

        // Randomized runs, including e_size values above EBITS.
        for (int i = 0; i < 16; i++)
            run_exp(int'($urandom_range(0, M - 1)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 15)), 1'b0);

        // Reset in the middle of the first SQUARE wait.
        @(negedge clk);
        en0 = en_total;
        base = 16'd4; exponent = 8'd13; e_size = 4'd4; r_red = NBITS'(RRED);
        start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
        cyc = 0;
        while ((en_total - en0) < 3 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check_val("sq_reached", 64'(en_total - en0), 64'd3);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run_exp(4, 13, 4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
